// File: rtl/imm_gen_pipe.sv
// RISC-V immediate generator with a valid/ready output register and a one-entry skid
// register, so the block sustains one beat per cycle under back-pressure.
module imm_gen_pipe #(
  parameter int XLEN  = 32,
  parameter int TAG_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [24:0]      instr_in,
  input  logic [2:0]       imm_src,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [XLEN-1:0]  out_imm,
  output logic [TAG_W-1:0] out_tag,
  output logic             out_err
);

  localparam logic [2:0] SRC_I     = 3'b000;
  localparam logic [2:0] SRC_S     = 3'b001;
  localparam logic [2:0] SRC_B     = 3'b010;
  localparam logic [2:0] SRC_J     = 3'b011;
  localparam logic [2:0] SRC_U     = 3'b100;
  localparam logic [2:0] SRC_SHAMT = 3'b101;
  localparam logic [2:0] SRC_ZIMM  = 3'b110;

  generate
    if (XLEN != 32 && XLEN != 64) begin : g_bad_xlen
      $error("imm_gen_pipe: XLEN must be 32 or 64");
    end
  endgenerate

  // Re-indexed so field slices read exactly like the ISA manual's inst[hi:lo].
  logic [31:7] inst;
  assign inst = instr_in;

  logic [31:0]      raw;
  logic             sext;
  logic             dec_err;
  logic [XLEN-1:0]  dec_imm;

  // NOTE: every variable gets a default before the case so no latch is inferred.
  always_comb begin
    raw     = '0;
    sext    = 1'b1;
    dec_err = 1'b0;
    case (imm_src)
      SRC_I: raw = {{20{inst[31]}}, inst[31:20]};
      SRC_S: raw = {{20{inst[31]}}, inst[31:25], inst[11:7]};
      SRC_B: raw = {{19{inst[31]}}, inst[31], inst[7], inst[30:25], inst[11:8], 1'b0};
      SRC_J: raw = {{11{inst[31]}}, inst[31], inst[19:12], inst[20], inst[30:21], 1'b0};
      SRC_U: raw = {inst[31:12], 12'b0};
      SRC_SHAMT: begin
        sext = 1'b0;
        raw  = (XLEN == 64) ? {26'b0, inst[25:20]} : {27'b0, inst[24:20]};
      end
      SRC_ZIMM: begin
        sext = 1'b0;
        raw  = {27'b0, inst[19:15]};
      end
      default: dec_err = 1'b1;
    endcase
  end

  assign dec_imm = sext ? XLEN'($signed(raw)) : XLEN'(raw);

  logic             sk_valid;
  logic [XLEN-1:0]  sk_imm;
  logic [TAG_W-1:0] sk_tag;
  logic             sk_err;
  logic             accept;

  // Ready depends only on registered state, never on out_ready.
  assign in_ready = ~sk_valid & rst_n;
  assign accept   = in_valid & in_ready;

  // NOTE: sequential state uses non-blocking assignments so every register samples
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      out_imm   <= '0;
      out_tag   <= '0;
      out_err   <= 1'b0;
      sk_valid  <= 1'b0;
    end else if (!out_valid || out_ready) begin
      if (sk_valid) begin
        out_valid <= 1'b1;
        out_imm   <= sk_imm;
        out_tag   <= sk_tag;
        out_err   <= sk_err;
        sk_valid  <= 1'b0;
      end else if (accept) begin
        out_valid <= 1'b1;
        out_imm   <= dec_imm;
        out_tag   <= in_tag;
        out_err   <= dec_err;
      end else begin
        out_valid <= 1'b0;
      end
    end else if (accept) begin
      sk_valid <= 1'b1;
    end
  end

  // NOTE: skid payload is not reset; sk_valid alone says whether it means anything.
  always_ff @(posedge clk) begin
    if (accept && out_valid && !out_ready) begin
      sk_imm <= dec_imm;
      sk_tag <= in_tag;
      sk_err <= dec_err;
    end
  end

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: XLEN=32 and XLEN=64 instances share stimulus and are checked
// every cycle against a depth-2 FIFO model with arithmetic immediate decoding.
module tb_imm_gen_pipe;

  localparam int TAG_W = 8;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             in_valid = 1'b0;
  logic             out_ready = 1'b0;
  logic [31:0]      inst_drv = '0;
  logic [24:0]      instr_in;
  logic [2:0]       imm_src = '0;
  logic [TAG_W-1:0] in_tag = '0;

  logic             in_ready32, out_valid32, out_err32;
  logic [31:0]      out_imm32;
  logic [TAG_W-1:0] out_tag32;
  logic             in_ready64, out_valid64, out_err64;
  logic [63:0]      out_imm64;
  logic [TAG_W-1:0] out_tag64;

  assign instr_in = inst_drv[31:7];

  always #5 clk = ~clk;

  imm_gen_pipe #(.XLEN(32), .TAG_W(TAG_W)) dut32 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready32),
    .instr_in(instr_in), .imm_src(imm_src), .in_tag(in_tag),
    .out_valid(out_valid32), .out_ready(out_ready), .out_imm(out_imm32),
    .out_tag(out_tag32), .out_err(out_err32)
  );

  imm_gen_pipe #(.XLEN(64), .TAG_W(TAG_W)) dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready64),
    .instr_in(instr_in), .imm_src(imm_src), .in_tag(in_tag),
    .out_valid(out_valid64), .out_ready(out_ready), .out_imm(out_imm64),
    .out_tag(out_tag64), .out_err(out_err64)
  );

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Zero-extended field inst[lo+n-1:lo] as a signed 64-bit number.
  function automatic longint fld(input logic [31:0] inst, input int lo, input int n);
    logic [31:0] v;
    v = (inst >> lo) & ((32'd1 << n) - 32'd1);
    return longint'({32'b0, v});
  endfunction

  // Immediate as plain weighted sums of instruction fields; sign comes from sx>>>k.
  function automatic logic [63:0] ref_imm(input logic [31:0] inst, input logic [2:0] src,
                                          input int xlen);
    longint sx, s, r;
    sx = $signed(inst);
    s  = sx >>> 31;
    case (src)
      3'd0: r = sx >>> 20;
      3'd1: r = (sx >>> 25) * 32 + fld(inst, 7, 5);
      3'd2: r = s * 4096 + fld(inst, 7, 1) * 2048 + fld(inst, 25, 6) * 32 + fld(inst, 8, 4) * 2;
      3'd3: r = s * 1048576 + fld(inst, 12, 8) * 4096 + fld(inst, 20, 1) * 2048
                + fld(inst, 21, 10) * 2;
      3'd4: r = (sx >>> 12) * 4096;
      3'd5: r = fld(inst, 20, (xlen == 64) ? 6 : 5);
      3'd6: r = fld(inst, 15, 5);
      default: r = 0;
    endcase
    if (xlen == 32) r = r & 64'hFFFF_FFFF;
    return r;
  endfunction

  typedef struct {
    logic [31:0]      inst;
    logic [2:0]       src;
    logic [TAG_W-1:0] tag;
  } beat_t;

  beat_t q[$];
  bit    m_fire, m_acc;
  beat_t m_beat;

  // Model: a FIFO holding at most two beats; head is what the outputs show.
  always @(posedge clk) begin
    if (!rst_n) begin
      q.delete();
    end else begin
      m_fire = (q.size() > 0) && out_ready;
      m_acc  = in_valid && (q.size() < 2);
      if (m_fire) void'(q.pop_front());
      if (m_acc) begin
        m_beat.inst = inst_drv;
        m_beat.src  = imm_src;
        m_beat.tag  = in_tag;
        q.push_back(m_beat);
      end
    end
  end

  bit          cmp_en = 1'b0;
  int          fire_cnt = 0;
  logic        exp_ready, exp_valid;
  logic [63:0] e32, e64;

  always @(negedge clk) begin
    if (cmp_en) begin
      exp_ready = rst_n && (q.size() < 2);
      exp_valid = (q.size() > 0);
      check("in_ready32", in_ready32, exp_ready);
      check("in_ready64", in_ready64, exp_ready);
      check("out_valid32", out_valid32, exp_valid);
      check("out_valid64", out_valid64, exp_valid);
      if (exp_valid) begin
        e32 = ref_imm(q[0].inst, q[0].src, 32);
        e64 = ref_imm(q[0].inst, q[0].src, 64);
        check("out_imm32", out_imm32, e32);
        check("out_imm64", out_imm64, e64);
        check("out_tag32", out_tag32, q[0].tag);
        check("out_tag64", out_tag64, q[0].tag);
        check("out_err32", out_err32, q[0].src == 3'd7);
        check("out_err64", out_err64, q[0].src == 3'd7);
      end
      if (out_valid32 && out_ready) fire_cnt++;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One beat through an empty pipe with out_ready=1; literal results one cycle later.
  task automatic send_lit(input string name, input logic [31:0] inst, input logic [2:0] src,
                          input logic [31:0] exp32, input logic [63:0] exp64, input logic err);
    logic [63:0] m;
    m = ref_imm(inst, src, 64);
    check({name, "_model64"}, m, exp64);
    m = ref_imm(inst, src, 32);
    check({name, "_model32"}, m, {32'b0, exp32});
    out_ready = 1'b1;
    in_valid  = 1'b1;
    inst_drv  = inst;
    imm_src   = src;
    in_tag    = 8'hA5;
    tick();
    in_valid = 1'b0;
    inst_drv = $urandom;
    @(negedge clk);
    check({name, "_valid"}, out_valid32, 1'b1);
    check({name, "_imm32"}, out_imm32, exp32);
    check({name, "_imm64"}, out_imm64, exp64);
    check({name, "_err"}, out_err32, err);
    check({name, "_tag"}, out_tag64, 8'hA5);
    tick();
  endtask

  logic [31:0] held_imm;

  initial begin
    // Reset held for several edges with a beat offered.
    in_valid = 1'b1;
    inst_drv = $urandom;
    for (int i = 0; i < 3; i++) begin
      tick();
      cmp_en = 1'b1;
      @(negedge clk);
      check("rst_in_ready", in_ready32, 1'b0);
      check("rst_out_valid", out_valid64, 1'b0);
      check("rst_out_imm", out_imm64, 64'd0);
      check("rst_out_err", out_err32, 1'b0);
      check("rst_out_tag", out_tag32, 8'd0);
    end
    tick();
    rst_n    = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("release_in_ready", in_ready32, 1'b1);
    tick();

    send_lit("I",     32'hFFF0_0093, 3'd0, 32'hFFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0);
    send_lit("B",     32'hFE00_0EE3, 3'd2, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    send_lit("B_b11", 32'hFE00_0E63, 3'd2, 32'hFFFF_F7FC, 64'hFFFF_FFFF_FFFF_F7FC, 1'b0);
    send_lit("J",     32'h0010_006F, 3'd3, 32'h0000_0800, 64'h0000_0000_0000_0800, 1'b0);
    send_lit("U",     32'h1234_50B7, 3'd4, 32'h1234_5000, 64'h0000_0000_1234_5000, 1'b0);
    send_lit("S",     32'hFE11_2E23, 3'd1, 32'hFFFF_FFFC, 64'hFFFF_FFFF_FFFF_FFFC, 1'b0);
    send_lit("U_neg", 32'h8000_0037, 3'd4, 32'h8000_0000, 64'hFFFF_FFFF_8000_0000, 1'b0);
    send_lit("SHAMT", 32'h03F0_1013, 3'd5, 32'h0000_001F, 64'h0000_0000_0000_003F, 1'b0);
    send_lit("ZIMM",  32'h000F_8073, 3'd6, 32'h0000_001F, 64'h0000_0000_0000_001F, 1'b0);
    send_lit("RSVD",  32'hFFFF_FFFF, 3'd7, 32'h0000_0000, 64'h0000_0000_0000_0000, 1'b1);

    // Back-pressure: tags 1,2,3 offered while stalled.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    imm_src   = 3'd0;
    inst_drv  = 32'h7FF0_0000;
    in_tag    = 8'd1;
    @(negedge clk);
    check("bp_ready1", in_ready32, 1'b1);
    tick();
    inst_drv = $urandom;
    in_tag   = 8'd2;
    @(negedge clk);
    check("bp_ready2", in_ready32, 1'b1);
    check("bp_head1", out_tag32, 8'd1);
    held_imm = out_imm32;
    tick();
    inst_drv = $urandom;
    in_tag   = 8'd3;
    @(negedge clk);
    check("bp_ready3", in_ready32, 1'b0);
    check("bp_hold_tag", out_tag32, 8'd1);
    check("bp_hold_imm", out_imm32, held_imm);
    tick();
    out_ready = 1'b1;
    @(negedge clk);
    check("bp_out1", out_tag32, 8'd1);
    tick();
    @(negedge clk);
    check("bp_out2", out_tag32, 8'd2);
    check("bp_ready_again", in_ready32, 1'b1);
    tick();
    in_valid = 1'b0;
    @(negedge clk);
    check("bp_out3", out_tag32, 8'd3);
    tick();
    @(negedge clk);
    check("bp_drained", out_valid32, 1'b0);
    tick();

    // Streaming: 16 back-to-back beats.
    fire_cnt = 0;
    for (int k = 0; k < 16; k++) begin
      in_valid = 1'b1;
      inst_drv = $urandom;
      imm_src  = 3'($urandom_range(0, 7));
      in_tag   = 8'(k + 16);
      tick();
    end
    in_valid = 1'b0;
    tick();
    check("stream_count", fire_cnt, 16);
    @(negedge clk);
    check("stream_empty", out_valid32, 1'b0);
    tick();

    // Reset with both registers full.
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int k = 0; k < 2; k++) begin
      inst_drv = $urandom;
      in_tag   = 8'(k + 40);
      tick();
    end
    in_valid = 1'b0;
    @(negedge clk);
    check("full_ready", in_ready32, 1'b0);
    tick();
    rst_n = 1'b0;
    @(negedge clk);
    check("mid_rst_ready", in_ready64, 1'b0);
    tick();
    rst_n = 1'b1;
    @(negedge clk);
    check("mid_rst_valid", out_valid32, 1'b0);
    check("mid_rst_ready_after", in_ready32, 1'b1);
    tick();

    // Randomized traffic with occasional resets.
    for (int c = 0; c < 3000; c++) begin
      rst_n     = ($urandom_range(0, 299) != 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 2) != 0);
      inst_drv  = $urandom;
      imm_src   = 3'($urandom_range(0, 7));
      in_tag    = 8'($urandom);
      tick();
    end
    rst_n     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b1;
    repeat (4) tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
